// File: rtl/bp_sigmoid_update.sv
// Backward-pass SGD update for one sigmoid neuron.
// One shared saturating fixed-point multiply chain, one weight per cycle.
module bp_sigmoid_update #(
   parameter int NUM   = 2,
   parameter int WIDTH = 32,
   parameter int FRAC  = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_start,
   input  logic [WIDTH-1:0]       i_err,
   input  logic [WIDTH-1:0]       i_a,
   input  logic [NUM*WIDTH-1:0]   i_k,
   input  logic [NUM*WIDTH-1:0]   i_w,
   input  logic [WIDTH-1:0]       i_b,
   input  logic [WIDTH-1:0]       i_lr,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_wr,
   output logic [NUM*WIDTH-1:0]   o_w,
   output logic [WIDTH-1:0]       o_b,
   output logic [WIDTH-1:0]       o_delta,
   output logic [NUM*WIDTH-1:0]   o_err_prev
);

   localparam int JW = (NUM > 1) ? $clog2(NUM) : 1;
   localparam logic [JW-1:0] LAST = JW'(NUM - 1);

   localparam logic signed [WIDTH-1:0] ONE =
      {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
   localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [2*WIDTH-1:0] P_MAX =
      {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [2*WIDTH-1:0] P_MIN =
      {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE, SIG, DLT, UPD, BIAS, WRITE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic signed [WIDTH-1:0] r_err, r_a, r_b, r_lr, r_s, r_delta;
   logic signed [WIDTH-1:0] r_k  [NUM];
   logic signed [WIDTH-1:0] r_w  [NUM];
   logic signed [WIDTH-1:0] r_ep [NUM];
   logic [JW-1:0]           r_j;

   logic signed [WIDTH-1:0] w_kj, w_wj, w_g, w_step, w_wnew, w_ep;
   logic signed [WIDTH-1:0] w_s, w_bstep;

   // Full-precision product, floor shift, clamp to the word range.
   function automatic logic signed [WIDTH-1:0] fx_mul(
      input logic signed [WIDTH-1:0] x,
      input logic signed [WIDTH-1:0] y
   );
      logic signed [2*WIDTH-1:0] p;
      p = $signed({{WIDTH{x[WIDTH-1]}}, x}) *
          $signed({{WIDTH{y[WIDTH-1]}}, y});
      p = p >>> FRAC;
      if (p > P_MAX) return S_MAX;
      if (p < P_MIN) return S_MIN;
      return p[WIDTH-1:0];
   endfunction

   function automatic logic signed [WIDTH-1:0] fx_sub(
      input logic signed [WIDTH-1:0] x,
      input logic signed [WIDTH-1:0] y
   );
      logic signed [WIDTH:0] d;
      d = {x[WIDTH-1], x} - {y[WIDTH-1], y};
      if (d[WIDTH] != d[WIDTH-1]) return d[WIDTH] ? S_MIN : S_MAX;
      return d[WIDTH-1:0];
   endfunction

   assign w_kj    = r_k[r_j];
   assign w_wj    = r_w[r_j];
   assign w_g     = fx_mul(r_delta, w_kj);
   assign w_step  = fx_mul(r_lr, w_g);
   assign w_wnew  = fx_sub(w_wj, w_step);
   assign w_ep    = fx_mul(r_delta, w_wj);
   assign w_s     = fx_mul(r_a, fx_sub(ONE, r_a));
   assign w_bstep = fx_mul(r_lr, r_delta);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (i_start) w_next = SIG;
         SIG:     w_next = DLT;
         DLT:     w_next = UPD;
         UPD:     if (r_j == LAST) w_next = BIAS;
         BIAS:    w_next = WRITE;
         WRITE:   w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      o_busy = (r_state != IDLE);
      o_wr   = (r_state == WRITE);
      o_done = (r_state == WRITE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_lr    <= '0;
         r_s     <= '0;
         r_delta <= '0;
         r_j     <= '0;
         for (int j = 0; j < NUM; j++) begin
            r_k[j]  <= '0;
            r_w[j]  <= '0;
            r_ep[j] <= '0;
         end
      end else begin
         unique case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_err <= i_err;
                  r_a   <= i_a;
                  r_b   <= i_b;
                  r_lr  <= i_lr;
                  r_j   <= '0;
                  for (int j = 0; j < NUM; j++) begin
                     r_k[j] <= i_k[j*WIDTH +: WIDTH];
                     r_w[j] <= i_w[j*WIDTH +: WIDTH];
                  end
               end
            end
            SIG: r_s <= w_s;
            DLT: r_delta <= fx_mul(r_err, r_s);
            UPD: begin
               // err_prev reads w_j before it is overwritten this cycle
               r_w[r_j]  <= w_wnew;
               r_ep[r_j] <= w_ep;
               if (r_j != LAST) r_j <= r_j + 1'b1;
            end
            BIAS: r_b <= fx_sub(r_b, w_bstep);
            default: ;
         endcase
      end
   end

   assign o_b     = r_b;
   assign o_delta = r_delta;

   for (genvar g = 0; g < NUM; g++) begin : g_out
      assign o_w[g*WIDTH +: WIDTH]        = r_w[g];
      assign o_err_prev[g*WIDTH +: WIDTH] = r_ep[g];
   end

endmodule

// File: tb/tb_bp_sigmoid_update.sv
// Scoreboard bench for bp_sigmoid_update: arithmetic model on accept,
// monitor compares on every write strobe.
module tb_bp_sigmoid_update;

   localparam int NUM = 2;
   localparam int W   = 32;
   localparam int F   = 24;
   localparam int LAT = NUM + 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             i_start;
   logic [W-1:0]     i_err, i_a, i_b, i_lr;
   logic [NUM*W-1:0] i_k, i_w;
   logic             o_busy, o_done, o_wr;
   logic [NUM*W-1:0] o_w, o_err_prev;
   logic [W-1:0]     o_b, o_delta;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [W-1:0]     d;
      logic [W-1:0]     b;
      logic [NUM*W-1:0] w;
      logic [NUM*W-1:0] ep;
      logic [31:0]      cyc;
   } exp_t;

   exp_t sb[$];
   int unsigned cyc = 0;
   int unsigned next_free = 0;

   bp_sigmoid_update #(.NUM(NUM), .WIDTH(W), .FRAC(F)) dut (
      .clk(clk), .rst(rst), .i_start(i_start),
      .i_err(i_err), .i_a(i_a), .i_k(i_k), .i_w(i_w),
      .i_b(i_b), .i_lr(i_lr),
      .o_busy(o_busy), .o_done(o_done), .o_wr(o_wr),
      .o_w(o_w), .o_b(o_b), .o_delta(o_delta),
      .o_err_prev(o_err_prev)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", n, act, exp);
      end
   endtask

   function automatic longint sx(input logic [W-1:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint clampv(input longint v);
      if (v > 64'sd2147483647) return 64'sd2147483647;
      if (v < -64'sd2147483648) return -64'sd2147483648;
      return v;
   endfunction

   function automatic longint fm(input longint x, input longint y);
      return clampv((x * y) >>> F);
   endfunction

   function automatic longint fs(input longint x, input longint y);
      return clampv(x - y);
   endfunction

   function automatic exp_t model();
      exp_t e;
      longint s, d, g, lr, wj;
      lr = sx(i_lr);
      s  = fm(sx(i_a), fs(longint'(1) <<< F, sx(i_a)));
      d  = fm(sx(i_err), s);
      e  = '0;
      e.d = d[W-1:0];
      for (int j = 0; j < NUM; j++) begin
         wj = sx(i_w[j*W +: W]);
         g  = fm(d, sx(i_k[j*W +: W]));
         e.w[j*W +: W]  = W'(fs(wj, fm(lr, g)));
         e.ep[j*W +: W] = W'(fm(d, wj));
      end
      e.b = W'(fs(sx(i_b), fm(lr, d)));
      return e;
   endfunction

   // Reference: accept whenever the engine is free by its own timing rule.
   always @(posedge clk) begin
      exp_t e;
      cyc++;
      if (rst) begin
         sb.delete();
         next_free = cyc + 1;
      end else if (i_start && cyc >= next_free) begin
         e = model();
         e.cyc = cyc;
         sb.push_back(e);
         next_free = cyc + NUM + 5;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && (o_wr || o_done)) begin
         if (sb.size() == 0) begin
            chk("unexpected_wr", {126'd0, o_wr, o_done}, 128'd0);
         end else begin
            e = sb.pop_front();
            chk("wr", 128'(o_wr), 128'd1);
            chk("done", 128'(o_done), 128'd1);
            chk("busy_at_wr", 128'(o_busy), 128'd1);
            chk("latency", 128'(cyc), 128'(e.cyc + LAT));
            chk("delta", 128'(o_delta), 128'(e.d));
            chk("bias", 128'(o_b), 128'(e.b));
            chk("weights", 128'(o_w), 128'(e.w));
            chk("err_prev", 128'(o_err_prev), 128'(e.ep));
         end
      end
   end

   task automatic set_vec(input logic [W-1:0] a, input logic [W-1:0] err,
                          input logic [W-1:0] k0, input logic [W-1:0] k1,
                          input logic [W-1:0] w0, input logic [W-1:0] w1,
                          input logic [W-1:0] b, input logic [W-1:0] lr);
      i_a = a; i_err = err; i_k = {k1, k0}; i_w = {w1, w0};
      i_b = b; i_lr = lr;
   endtask

   task automatic scramble();
      i_a = $urandom; i_err = $urandom; i_b = $urandom; i_lr = $urandom;
      i_k = {$urandom, $urandom}; i_w = {$urandom, $urandom};
   endtask

   // Pulse start with the current vector, then scramble inputs and wait.
   task automatic run1();
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      scramble();
      repeat (NUM + 6) @(negedge clk);
   endtask

   task automatic chk_zero(input string n);
      chk({n, "_busy"}, 128'(o_busy), 128'd0);
      chk({n, "_wr"}, 128'({o_wr, o_done}), 128'd0);
      chk({n, "_delta"}, 128'(o_delta), 128'd0);
      chk({n, "_b"}, 128'(o_b), 128'd0);
      chk({n, "_w"}, 128'(o_w), 128'd0);
      chk({n, "_ep"}, 128'(o_err_prev), 128'd0);
   endtask

   initial begin
      int t;
      rst = 1'b1;
      i_start = 1'b0;
      set_vec('0, '0, '0, '0, '0, '0, '0, '0);
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      set_vec(32'h00800000, 32'h01000000, 32'h01000000, 32'h02000000,
              32'h00800000, 32'hFF800000, 32'h0, 32'h00800000);
      run1();
      set_vec(32'h00800000, 32'h01000000, 32'h9C000000, 32'h01000000,
              32'h7FFFFFFF, 32'h00100000, 32'h0, 32'h01000000);
      run1();
      set_vec(32'h00800000, 32'h01000000, 32'h64000000, 32'h01000000,
              32'h80000000, 32'h00100000, 32'h0, 32'h01000000);
      run1();
      set_vec(32'h0, 32'h01000000, 32'h01000000, 32'h02000000,
              32'h00800000, 32'hFF800000, 32'h00300000, 32'h00800000);
      run1();
      set_vec(32'h01000000, 32'h01000000, 32'h01000000, 32'h02000000,
              32'h00800000, 32'hFF800000, 32'h00300000, 32'h00800000);
      run1();

      for (int i = 0; i < 300; i++) begin
         scramble();
         if ($urandom_range(0, 1) == 0) i_a = $urandom_range(0, 1 << F);
         if ($urandom_range(0, 1) == 0) i_lr = $urandom_range(0, 1 << F);
         i_start = ($urandom_range(0, 3) == 0);
         @(negedge clk);
      end
      i_start = 1'b0;
      repeat (NUM + 6) @(negedge clk);

      set_vec(32'h00400000, 32'hFF000000, 32'h00800000, 32'h03000000,
              32'h00200000, 32'hFFC00000, 32'h00100000, 32'h00400000);
      i_start = 1'b1;
      repeat (20) @(negedge clk);
      i_start = 1'b0;
      repeat (NUM + 6) @(negedge clk);

      set_vec(32'h00800000, 32'h01000000, 32'h01000000, 32'h02000000,
              32'h00800000, 32'hFF800000, 32'h0, 32'h00800000);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_zero("rst_upd");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      set_vec(32'h00800000, 32'h01000000, 32'h01000000, 32'h02000000,
              32'h00800000, 32'hFF800000, 32'h0, 32'h00800000);
      run1();

      t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("drain", 128'(sb.size()), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bp_sigmoid_update.md
Name: bp_sigmoid_update

Overview:
Backward-pass weight-update engine for one sigmoid neuron with NUM inputs and one bias. It takes the neuron's activation, output error, inputs and current weights/bias, and computes the local delta = err·a·(1−a). From that delta it produces updated weights/bias (SGD step) and a one-cycle write strobe that feeds the forward neuron's wr / i_w / i_b ports. It also produces the error propagated to the previous layer, delta·w_j, computed with the pre-update weights.

Parameters:
NUM, 2, number of neuron inputs/weights
WIDTH, 32, signed fixed-point word width
FRAC, 24, fractional bits (1.0 = 1<<FRAC)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
i_start  in  1  start request; accepted only in IDLE
i_err  in  WIDTH  dE/da of this neuron
i_a  in  WIDTH  neuron activation (sigmoid output)
i_k  in  NUM*WIDTH  forward inputs; element j at [j*WIDTH +: WIDTH]
i_w  in  NUM*WIDTH  current weights, same packing
i_b  in  WIDTH  current bias
i_lr  in  WIDTH  learning rate
o_busy  out  1  high from start accept until o_done
o_done  out  1  one-cycle completion pulse
o_wr  out  1  one-cycle weight write strobe (drives forward neuron wr)
o_w  out  NUM*WIDTH  updated weights (drives forward neuron i_w)
o_b  out  WIDTH  updated bias (drives forward neuron i_b)
o_delta  out  WIDTH  local delta
o_err_prev  out  NUM*WIDTH  delta·w_j (old w_j) per input, same packing

Behaviour:
- Reset (async, any state): FSM → IDLE; all outputs and internal registers = 0; no o_wr pulse.
- On the accepting edge (IDLE && i_start), latch i_err, i_a, i_k, i_w, i_b, i_lr. Inputs may change afterwards. o_busy rises the same edge.
- i_start outside IDLE is ignored; it is not queued.
- FSM: IDLE → SIG → DLT → UPD (NUM cycles, index j = 0..NUM−1) → BIAS → WRITE → IDLE.
  - SIG: s = a ⊗ (ONE − a).
  - DLT: delta = err ⊗ s; register delta to o_delta.
  - UPD j: g = delta ⊗ k_j; w_j' = w_j − (lr ⊗ g); err_prev_j = delta ⊗ w_j (old value). One element per cycle; single multiplier chain reused.
  - BIAS: b' = b − (lr ⊗ delta).
  - WRITE: o_wr = 1 and o_done = 1 for exactly this cycle. o_w/o_b/o_err_prev are already valid here. o_busy deasserts on leaving WRITE.
- Latency: o_wr/o_done are high in the (NUM+4)th cycle after the accepting edge.
- ⊗ = fixed-point multiply: full 2·WIDTH signed product, arithmetic shift right by FRAC (truncate toward −∞), then saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Subtractions saturate to the same range; there is no wraparound.
- o_w, o_b, o_delta and o_err_prev hold their values after done until the next accepted start. They may update per-element during UPD. The consumer must sample them only on o_wr.
- Back-to-back operation: i_start asserted in the cycle after o_done is accepted. There is no idle gap requirement.
- NUM = 1 must work (UPD = 1 cycle).

Test Plan:
- NUM=2, FRAC=24: a=0x00800000, err=0x01000000, k={0x01000000,0x02000000}, w={0x00800000,0xFF800000}, b=0, lr=0x00800000 → o_delta=0x00400000, o_w={0x00600000,0xFF400000}, o_b=0xFFE00000, o_err_prev={0x00200000,0xFFE00000}, o_wr=o_done=1 exactly in cycle 6 after start.
- Saturation: w0=0x7FFFFFFF, lr=0x01000000, a=0x00800000, err=0x01000000, k0=0x9C000000 (−100.0) → w0'=0x7FFFFFFF, no wrap; symmetric negative case → 0x80000000.
- i_start held high continuously for 20 cycles → one run per NUM+5 cycles; pulses during busy are ignored; o_busy is never high during o_done+1 IDLE accept gaps incorrectly.
- Reset asserted in UPD → outputs 0 immediately (async), no o_wr; a subsequent start produces correct results.
- Inputs changed on the cycle after start → results match the latched values (rerun of first vector).
- a=0 or a=0x01000000 → delta=0, weights/bias unchanged, o_err_prev=0, o_wr still pulses.
